weight_tile_assembler: RTL and testbench
========================================

# weight_tile_assembler

Receiving end of the weight-address stream: captures the weight words returned from weight memory, one per cycle, and assembles them into S2P×S2P tiles for the GEMM array. Beats arrive in the order the weight address generator issues them: column-in-tile inner, row-in-tile outer. Each beat carries a padding flag for out-of-matrix positions. A ping-pong pair of tile banks lets one tile fill while the previous one is held for the array, with a valid/ready handshake on the tile side.

## Interface
- S2P, 8, tile edge; one tile = S2P*S2P beats
- DATA_W, 8, weight element width
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of both banks, counters and error flag
- in_valid  in  1  weight beat present (aligned to memory read data)
- in_data  in  DATA_W  weight element
- in_pad  in  1  beat is padding (out of matrix)
- in_ready  out  1  current write bank can accept a beat
- tile_valid  out  1  read bank holds a complete tile
- tile_ready  in  1  array consumes tile
- tile_data  out  S2P*S2P*DATA_W  element (r,c) at bits [(r*S2P+c)*DATA_W +: DATA_W]
- err_overflow  out  1  sticky: beat arrived while in_ready=0

## Operation
- Two banks (0/1), each S2P*S2P registers plus state EMPTY, FILLING, FULL. Write pointer wr_bank and read pointer rd_bank both reset to 0.
- Beat counter col_cnt, row_cnt (log2(S2P) bits each) addresses the write bank. Accepted beat = in_valid && in_ready.
- Each accepted beat stores to (row_cnt, col_cnt) of wr_bank. col_cnt increments; it wraps at S2P-1 and row_cnt increments on that wrap.
- On beat (S2P-1, S2P-1): both counters wrap to 0, wr_bank goes FULL, and wr_bank toggles.
- Bank state transitions:
  - EMPTY→FILLING on its first beat.
  - FILLING→FULL on its last beat.
  - FULL→EMPTY on tile handshake (tile_valid && tile_ready) while it is rd_bank; rd_bank then toggles.
- in_ready = (state[wr_bank] != FULL).
- tile_valid = (state[rd_bank] == FULL); tile_data drives bank rd_bank directly from registers.
- Beat with in_valid && !in_ready: data dropped, counters unchanged, err_overflow←1. It holds until flush or reset.
- Simultaneous last write to one bank and release of the other in the same cycle: both take effect, so throughput is one tile per S2P*S2P cycles with no bubble.
- flush: all bank states EMPTY, counters 0, pointers 0, err_overflow 0. Bank data is not cleared. Takes priority over a beat in the same cycle.
- Reset mid-tile: partial tile discarded, same end state as flush, and bank data cleared to 0.

## Timing
- Reset values: in_ready=1, tile_valid=0, tile_data=0, err_overflow=0.
- Latency: a tile's last beat accepted in cycle N gives tile_valid=1 in cycle N+1.
- tile_valid stays high and tile_data stays stable until the handshake cycle. tile_valid drops the next cycle unless the other bank is already FULL, in which case it stays high with the new data.
- in_ready falls the cycle after both banks become FULL. It rises the cycle after a handshake frees a bank.
- Upstream must gate its enable with in_ready, because the address generator has no stall. Any beat dropped while in_ready=0 raises err_overflow.

## Configuration
- WEIGHT_TILE_PAD_ZERO_EN:
  - Defined: a beat with in_pad=1 stores 0 regardless of in_data. This is needed because padded positions read address 0, which holds a real weight.
  - Undefined: in_pad is ignored and in_data is stored as-is; memory address 0 must then be reserved as zero.

## Test plan
(S2P=8, DATA_W=8 throughout.)
- Single tile: 64 beats with in_data=k (k=0..63), tile_ready=0. Required: tile_valid=1 one cycle after beat 63, and element (r,c) = 8r+c.
- Back-to-back tiles:
  - 192 continuous beats with tile_ready=1. Required: three handshakes, in_ready never 0, err_overflow=0.
  - Same stream with tile_ready=0. Required: in_ready=0 after beat 128; a 129th beat sets err_overflow=1; tiles 0 and 1 are intact.
- Padding, with WEIGHT_TILE_PAD_ZERO_EN defined: in_data=8'hAA on all beats, in_pad=1 for col≥5. Required: columns 5..7 = 0 and other elements = 8'hAA. With the macro undefined: all elements = 8'hAA.
- Flush mid-tile: flush after 20 beats, then 64 beats of 8'h11. Required: the resulting tile is all 8'h11, err_overflow=0.
- Async reset asserted mid-fill with bank 0 FULL. Required: immediately tile_valid=0, in_ready=1, tile_data=0; the next 64 beats land in bank 0.

Source files
------------

// File: rtl/weight_tile_assembler_if.sv
// Weight-beat input stream and assembled-tile output bundle for weight_tile_assembler.
// The master side drives beats and tile_ready; the slave side is the assembler.
interface weight_tile_assembler_if #(
   parameter int S2P    = 8,
   parameter int DATA_W = 8
);
   logic                      in_valid;
   logic [DATA_W-1:0]         in_data;
   logic                      in_pad;
   logic                      in_ready;
   logic                      tile_valid;
   logic                      tile_ready;
   logic [S2P*S2P*DATA_W-1:0] tile_data;

   modport master (
      output in_valid, in_data, in_pad, tile_ready,
      input  in_ready, tile_valid, tile_data
   );

   modport slave (
      input  in_valid, in_data, in_pad, tile_ready,
      output in_ready, tile_valid, tile_data
   );
endinterface

// File: rtl/weight_tile_assembler.sv
// Assembles weight beats (column inner, row outer) into S2PxS2P tiles using ping-pong banks.
// Optional macro WEIGHT_TILE_PAD_ZERO_EN: padded beats (in_pad=1) store zero instead of in_data.
module weight_tile_assembler #(
   parameter int S2P    = 8,
   parameter int DATA_W = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    flush,
   weight_tile_assembler_if.slave  bus,
   output logic                    err_overflow
);
   localparam int              CW   = (S2P > 1) ? $clog2(S2P) : 1;
   localparam int              NE   = S2P * S2P;
   localparam int              IW   = (NE > 1) ? $clog2(NE) : 1;
   localparam logic [CW-1:0]   LAST = CW'(S2P - 1);

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_e;

   bank_state_e       state_q [2];
   bank_state_e       state_d [2];
   logic              wr_bank;
   logic              rd_bank;
   logic [CW-1:0]     col_cnt;
   logic [CW-1:0]     row_cnt;
   logic [DATA_W-1:0] mem [2][NE];
   logic [DATA_W-1:0] wr_word;
   logic [IW-1:0]     wr_idx;
   logic              accept;
   logic              last_beat;
   logic              tile_fire;

   assign bus.in_ready   = (state_q[wr_bank] != BANK_FULL);
   assign bus.tile_valid = (state_q[rd_bank] == BANK_FULL);

   // Flush wins over a same-cycle beat or handshake, so both are masked here.
   assign accept    = bus.in_valid && bus.in_ready && !flush;
   assign last_beat = accept && (col_cnt == LAST) && (row_cnt == LAST);
   assign tile_fire = bus.tile_valid && bus.tile_ready && !flush;
   assign wr_idx    = IW'(row_cnt) * IW'(S2P) + IW'(col_cnt);

`ifdef WEIGHT_TILE_PAD_ZERO_EN
   assign wr_word = bus.in_pad ? '0 : bus.in_data;
`else
   logic unused_pad;
   assign wr_word    = bus.in_data;
   assign unused_pad = bus.in_pad;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q[0] <= BANK_EMPTY;
         state_q[1] <= BANK_EMPTY;
      end else begin
         state_q[0] <= state_d[0];
         state_q[1] <= state_d[1];
      end
   end

   // Writes only touch a non-FULL bank and releases only a FULL one, so both can land in one cycle.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         state_d[b] = state_q[b];
         if (accept && (wr_bank == 1'(b)))
            state_d[b] = last_beat ? BANK_FULL : BANK_FILLING;
         if (tile_fire && (rd_bank == 1'(b)))
            state_d[b] = BANK_EMPTY;
         if (flush)
            state_d[b] = BANK_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col_cnt <= '0;
         row_cnt <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
      end else if (flush) begin
         col_cnt <= '0;
         row_cnt <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
      end else begin
         if (accept) begin
            if (col_cnt == LAST) begin
               col_cnt <= '0;
               if (row_cnt == LAST) begin
                  row_cnt <= '0;
                  wr_bank <= ~wr_bank;
               end else begin
                  row_cnt <= row_cnt + CW'(1);
               end
            end else begin
               col_cnt <= col_cnt + CW'(1);
            end
         end
         if (tile_fire)
            rd_bank <= ~rd_bank;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         err_overflow <= 1'b0;
      else if (flush)
         err_overflow <= 1'b0;
      else if (bus.in_valid && !bus.in_ready)
         err_overflow <= 1'b1;
   end

   // Reset clears bank contents; flush deliberately leaves them alone.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < NE; i++)
               mem[b][i] <= '0;
      end else if (accept) begin
         mem[wr_bank][wr_idx] <= wr_word;
      end
   end

   for (genvar i = 0; i < NE; i++) begin : g_tile_out
      assign bus.tile_data[i*DATA_W +: DATA_W] = mem[rd_bank][i];
   end
endmodule

// File: tb/tb_weight_tile_assembler.sv
// Directed self-checking bench for weight_tile_assembler (S2P=8, DATA_W=8).
// Padding expectations follow WEIGHT_TILE_PAD_ZERO_EN when it is defined for the build.
module tb_weight_tile_assembler;
   localparam int S2P    = 8;
   localparam int DATA_W = 8;
   localparam int NE     = S2P * S2P;
`ifdef WEIGHT_TILE_PAD_ZERO_EN
   localparam bit PAD_ON = 1'b1;
`else
   localparam bit PAD_ON = 1'b0;
`endif

   logic clk;
   logic rstn;
   logic flush;
   logic err_overflow;
   int   vec_count;
   int   err_count;

   weight_tile_assembler_if #(.S2P(S2P), .DATA_W(DATA_W)) bus ();

   weight_tile_assembler #(.S2P(S2P), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .flush        (flush),
      .bus          (bus),
      .err_overflow (err_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge so the DUT sees them stable at the rising edge.
   task automatic send_beat(input logic [7:0] d, input logic p);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_pad   = p;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_pad   = 1'b0;
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      bus.in_valid = 1'b0;
      flush        = 1'b1;
      @(negedge clk);
      flush        = 1'b0;
   endtask

   task automatic consume_tile();
      @(negedge clk);
      bus.tile_ready = 1'b1;
      @(negedge clk);
      bus.tile_ready = 1'b0;
   endtask

   task automatic test_reset();
      rstn           = 1'b0;
      flush          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_pad     = 1'b0;
      bus.tile_ready = 1'b0;
      #1;
      vec_count++;
      if (bus.in_ready !== 1'b1) begin err_count++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      vec_count++;
      if (bus.tile_valid !== 1'b0) begin err_count++; $display("[TB] FAIL reset_tile_valid: got %b expected 0", bus.tile_valid); end
      vec_count++;
      if (bus.tile_data !== '0) begin err_count++; $display("[TB] FAIL reset_tile_data: got nonzero expected 0"); end
      vec_count++;
      if (err_overflow !== 1'b0) begin err_count++; $display("[TB] FAIL reset_err: got %b expected 0", err_overflow); end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_single_tile();
      int bad;
      for (int k = 0; k < NE; k++) send_beat(8'(k), 1'b0);
      vec_count++;
      if (bus.tile_valid !== 1'b0) begin err_count++; $display("[TB] FAIL single_early_valid: got %b expected 0", bus.tile_valid); end
      idle_cycle();
      vec_count++;
      if (bus.tile_valid !== 1'b1) begin err_count++; $display("[TB] FAIL single_latency: got %b expected 1", bus.tile_valid); end
      vec_count++;
      if (bus.in_ready !== 1'b1) begin err_count++; $display("[TB] FAIL single_in_ready: got %b expected 1", bus.in_ready); end
      bad = 0;
      for (int r = 0; r < S2P; r++)
         for (int c = 0; c < S2P; c++)
            if (bus.tile_data[(r*S2P+c)*DATA_W +: DATA_W] !== 8'(8*r+c) && bad == 0) begin
               bad = 1;
               $display("[TB] FAIL single_elem(%0d,%0d): got %0h expected %0h", r, c,
                        bus.tile_data[(r*S2P+c)*DATA_W +: DATA_W], 8'(8*r+c));
            end
      vec_count++;
      err_count += bad;
      consume_tile();
      vec_count++;
      if (bus.tile_valid !== 1'b0) begin err_count++; $display("[TB] FAIL single_release: got %b expected 0", bus.tile_valid); end
   endtask

   task automatic test_back_to_back();
      int hs;
      int low;
      logic [7:0] e0;
      logic [7:0] e63;
      pulse_flush();
      hs  = 0;
      low = 0;
      bus.tile_ready = 1'b1;
      for (int i = 0; i < 3*NE + 4; i++) begin
         @(negedge clk);
         if (bus.tile_valid === 1'b1) begin
            e0  = 8'(NE*hs);
            e63 = 8'(NE*hs + 63);
            vec_count++;
            if (bus.tile_data[0 +: 8] !== e0 || bus.tile_data[63*8 +: 8] !== e63) begin
               err_count++;
               $display("[TB] FAIL b2b_tile%0d_data: got %0h/%0h expected %0h/%0h", hs,
                        bus.tile_data[0 +: 8], bus.tile_data[63*8 +: 8], e0, e63);
            end
            hs++;
         end
         if (i < 3*NE) begin
            if (bus.in_ready !== 1'b1) low++;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      bus.tile_ready = 1'b0;
      vec_count++;
      if (hs != 3) begin err_count++; $display("[TB] FAIL b2b_handshakes: got %0d expected 3", hs); end
      vec_count++;
      if (low != 0) begin err_count++; $display("[TB] FAIL b2b_in_ready_low: got %0d expected 0", low); end
      vec_count++;
      if (err_overflow !== 1'b0) begin err_count++; $display("[TB] FAIL b2b_err: got %b expected 0", err_overflow); end
   endtask

   task automatic test_stall_overflow();
      int bad;
      pulse_flush();
      bus.tile_ready = 1'b0;
      for (int i = 0; i <= 2*NE; i++) begin
         @(negedge clk);
         if (i == 2*NE - 1) begin
            vec_count++;
            if (bus.in_ready !== 1'b1) begin err_count++; $display("[TB] FAIL stall_ready_before: got %b expected 1", bus.in_ready); end
         end
         if (i == 2*NE) begin
            vec_count++;
            if (bus.in_ready !== 1'b0) begin err_count++; $display("[TB] FAIL stall_ready_after: got %b expected 0", bus.in_ready); end
         end
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(i);
      end
      idle_cycle();
      vec_count++;
      if (err_overflow !== 1'b1) begin err_count++; $display("[TB] FAIL stall_err_set: got %b expected 1", err_overflow); end
      bad = 0;
      for (int i = 0; i < NE; i++)
         if (bus.tile_data[i*8 +: 8] !== 8'(i) && bad == 0) begin
            bad = 1;
            $display("[TB] FAIL stall_tile0_elem%0d: got %0h expected %0h", i, bus.tile_data[i*8 +: 8], 8'(i));
         end
      vec_count++;
      err_count += bad;
      consume_tile();
      vec_count++;
      if (bus.tile_valid !== 1'b1) begin err_count++; $display("[TB] FAIL stall_next_valid: got %b expected 1", bus.tile_valid); end
      vec_count++;
      if (bus.in_ready !== 1'b1) begin err_count++; $display("[TB] FAIL stall_ready_rise: got %b expected 1", bus.in_ready); end
      bad = 0;
      for (int i = 0; i < NE; i++)
         if (bus.tile_data[i*8 +: 8] !== 8'(NE + i) && bad == 0) begin
            bad = 1;
            $display("[TB] FAIL stall_tile1_elem%0d: got %0h expected %0h", i, bus.tile_data[i*8 +: 8], 8'(NE + i));
         end
      vec_count++;
      err_count += bad;
      consume_tile();
      vec_count++;
      if (bus.tile_valid !== 1'b0 || err_overflow !== 1'b1) begin
         err_count++;
         $display("[TB] FAIL stall_drain: got valid=%b err=%b expected valid=0 err=1", bus.tile_valid, err_overflow);
      end
      pulse_flush();
      vec_count++;
      if (err_overflow !== 1'b0) begin err_count++; $display("[TB] FAIL stall_err_clear: got %b expected 0", err_overflow); end
   endtask

   task automatic test_padding();
      int bad;
      logic [7:0] exp_v;
      pulse_flush();
      for (int k = 0; k < NE; k++) send_beat(8'hAA, (k % S2P) >= 5);
      idle_cycle();
      vec_count++;
      if (bus.tile_valid !== 1'b1) begin err_count++; $display("[TB] FAIL pad_valid: got %b expected 1", bus.tile_valid); end
      bad = 0;
      for (int i = 0; i < NE; i++) begin
         exp_v = (PAD_ON && (i % S2P) >= 5) ? 8'h00 : 8'hAA;
         if (bus.tile_data[i*8 +: 8] !== exp_v && bad == 0) begin
            bad = 1;
            $display("[TB] FAIL pad_elem%0d: got %0h expected %0h", i, bus.tile_data[i*8 +: 8], exp_v);
         end
      end
      vec_count++;
      err_count += bad;
      consume_tile();
   endtask

   task automatic test_flush();
      int bad;
      pulse_flush();
      for (int k = 0; k < 20; k++) send_beat(8'h55, 1'b0);
      @(negedge clk);
      flush        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h99;
      @(negedge clk);
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      vec_count++;
      if (bus.tile_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         err_count++;
         $display("[TB] FAIL flush_state: got valid=%b ready=%b expected valid=0 ready=1", bus.tile_valid, bus.in_ready);
      end
      for (int k = 0; k < NE; k++) send_beat(8'h11, 1'b0);
      idle_cycle();
      vec_count++;
      if (bus.tile_valid !== 1'b1) begin err_count++; $display("[TB] FAIL flush_valid: got %b expected 1", bus.tile_valid); end
      bad = 0;
      for (int i = 0; i < NE; i++)
         if (bus.tile_data[i*8 +: 8] !== 8'h11 && bad == 0) begin
            bad = 1;
            $display("[TB] FAIL flush_elem%0d: got %0h expected 11", i, bus.tile_data[i*8 +: 8]);
         end
      vec_count++;
      err_count += bad;
      vec_count++;
      if (err_overflow !== 1'b0) begin err_count++; $display("[TB] FAIL flush_err: got %b expected 0", err_overflow); end
      consume_tile();
   endtask

   task automatic test_async_reset();
      int bad;
      pulse_flush();
      for (int k = 0; k < NE; k++) send_beat(8'h77, 1'b0);
      for (int k = 0; k < 10; k++) send_beat(8'h22, 1'b0);
      vec_count++;
      if (bus.tile_valid !== 1'b1) begin err_count++; $display("[TB] FAIL areset_pre_valid: got %b expected 1", bus.tile_valid); end
      #2 rstn = 1'b0;
      #1;
      vec_count++;
      if (bus.tile_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         err_count++;
         $display("[TB] FAIL areset_flags: got valid=%b ready=%b expected valid=0 ready=1", bus.tile_valid, bus.in_ready);
      end
      vec_count++;
      if (bus.tile_data !== '0) begin err_count++; $display("[TB] FAIL areset_data: got %0h expected 0", bus.tile_data[0 +: 8]); end
      idle_cycle();
      rstn = 1'b1;
      for (int k = 0; k < NE; k++) send_beat(8'h33, 1'b0);
      idle_cycle();
      vec_count++;
      if (bus.tile_valid !== 1'b1) begin err_count++; $display("[TB] FAIL areset_refill_valid: got %b expected 1", bus.tile_valid); end
      bad = 0;
      for (int i = 0; i < NE; i++)
         if (bus.tile_data[i*8 +: 8] !== 8'h33 && bad == 0) begin
            bad = 1;
            $display("[TB] FAIL areset_elem%0d: got %0h expected 33", i, bus.tile_data[i*8 +: 8]);
         end
      vec_count++;
      err_count += bad;
      consume_tile();
      vec_count++;
      if (bus.tile_valid !== 1'b0 || bus.tile_data !== '0) begin
         err_count++;
         $display("[TB] FAIL areset_bank1_clear: got valid=%b elem0=%0h expected valid=0 elem0=0",
                  bus.tile_valid, bus.tile_data[0 +: 8]);
      end
   endtask

   initial begin
      vec_count = 0;
      err_count = 0;
      test_reset();
      test_single_tile();
      test_back_to_back();
      test_stall_overflow();
      test_padding();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end
endmodule
